// File: rtl/vga_timing.sv
// Raster timing generator: free-running h/v beam counters advanced by a pixel-clock
// enable, with registered sync, data-enable and line/frame start strobes.
module vga_timing #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_en,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       de,
    output logic       hsync,
    output logic       vsync,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : gTotalCheck
            $error("vga_timing: H_TOTAL and V_TOTAL must not exceed 1024");
        end
    endgenerate

    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] hpos_q, hpos_d;
    logic [9:0] vpos_q, vpos_d;
    logic       de_q, de_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       lineStart_q, lineStart_d;
    logic       frameStart_q, frameStart_d;
    logic [7:0] frameCount_q, frameCount_d;

    logic [9:0] hNext;
    logic [9:0] vNext;

    // Sync and de are decoded from the next counter values so they register
    // on the same edge as hpos/vpos and never lag the beam position.
    always_comb begin
        hNext = hpos_q + 10'd1;
        vNext = vpos_q;
        if (hpos_q == H_LAST) begin
            hNext = '0;
            vNext = (vpos_q == V_LAST) ? '0 : vpos_q + 10'd1;
        end

        hpos_d       = hpos_q;
        vpos_d       = vpos_q;
        de_d         = de_q;
        hsync_d      = hsync_q;
        vsync_d      = vsync_q;
        frameCount_d = frameCount_q;
        lineStart_d  = 1'b0;
        frameStart_d = 1'b0;

        if (pix_en) begin
            hpos_d       = hNext;
            vpos_d       = vNext;
            de_d         = ({1'b0, hNext} < H_ACT) && ({1'b0, vNext} < V_ACT);
            hsync_d      = (({1'b0, hNext} >= HS_START) && ({1'b0, hNext} < HS_END))
                           ? SYNC_POL : ~SYNC_POL;
            vsync_d      = (({1'b0, vNext} >= VS_START) && ({1'b0, vNext} < VS_END))
                           ? SYNC_POL : ~SYNC_POL;
            lineStart_d  = (hNext == 10'd0);
            frameStart_d = (hNext == 10'd0) && (vNext == 10'd0);
            if (frameStart_d) begin
                frameCount_d = frameCount_q + 8'd1;
            end
        end
    end

    // Reset parks the beam on the last pixel so the first enabled edge starts a frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hpos_q       <= H_LAST;
            vpos_q       <= V_LAST;
            de_q         <= 1'b0;
            hsync_q      <= ~SYNC_POL;
            vsync_q      <= ~SYNC_POL;
            lineStart_q  <= 1'b0;
            frameStart_q <= 1'b0;
            frameCount_q <= '0;
        end else begin
            hpos_q       <= hpos_d;
            vpos_q       <= vpos_d;
            de_q         <= de_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            lineStart_q  <= lineStart_d;
            frameStart_q <= frameStart_d;
            frameCount_q <= frameCount_d;
        end
    end

    assign hpos        = hpos_q;
    assign vpos        = vpos_q;
    assign de          = de_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign line_start  = lineStart_q;
    assign frame_start = frameStart_q;
    assign frame_count = frameCount_q;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a default-timing instance for line-level behaviour and a
// tiny active-high-sync instance for whole-frame and frame-counter wrap behaviour.
module tb_vga_timing;

    // Small instance geometry: 15 pixels x 8 lines, 120 pixels per frame.
    localparam int BHA = 8, BHF = 2, BHS = 3, BHB = 2;
    localparam int BVA = 4, BVF = 1, BVS = 2, BVB = 1;
    localparam int BHT = BHA + BHF + BHS + BHB;
    localparam int BVT = BVA + BVF + BVS + BVB;
    localparam int AHT = 800, AVT = 525;

    logic clk = 1'b0;
    logic resetA = 1'b0, resetB = 1'b0;
    logic pixEnA = 1'b1, pixEnB = 1'b1;

    logic [9:0] hposA, vposA, hposB, vposB;
    logic       deA, hsyncA, vsyncA, lineStartA, frameStartA;
    logic       deB, hsyncB, vsyncB, lineStartB, frameStartB;
    logic [7:0] frameCountA, frameCountB;

    int checks = 0;
    int errors = 0;
    bit checkOn = 1'b0;

    // Model state: linear pixel index within the frame, plus strobes and frame tally.
    int posA, lsA, fsA, fcA;
    int posB, lsB, fsB, fcB;

    always #5 clk = ~clk;

    vga_timing dutA (
        .clk(clk), .reset(resetA), .pix_en(pixEnA),
        .hpos(hposA), .vpos(vposA), .de(deA), .hsync(hsyncA), .vsync(vsyncA),
        .line_start(lineStartA), .frame_start(frameStartA), .frame_count(frameCountA)
    );

    vga_timing #(
        .H_ACTIVE(BHA), .H_FP(BHF), .H_SYNC(BHS), .H_BP(BHB),
        .V_ACTIVE(BVA), .V_FP(BVF), .V_SYNC(BVS), .V_BP(BVB), .SYNC_POL(1'b1)
    ) dutB (
        .clk(clk), .reset(resetB), .pix_en(pixEnB),
        .hpos(hposB), .vpos(vposB), .de(deB), .hsync(hsyncB), .vsync(vsyncB),
        .line_start(lineStartB), .frame_start(frameStartB), .frame_count(frameCountB)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(posedge clk or posedge resetA) begin
        if (resetA) begin
            posA = AHT * AVT - 1; lsA = 0; fsA = 0; fcA = 0;
        end else if (pixEnA) begin
            posA = (posA + 1) % (AHT * AVT);
            lsA  = (posA % AHT == 0);
            fsA  = (posA == 0);
            if (fsA != 0) fcA = (fcA + 1) % 256;
        end else begin
            lsA = 0; fsA = 0;
        end
    end

    always @(posedge clk or posedge resetB) begin
        if (resetB) begin
            posB = BHT * BVT - 1; lsB = 0; fsB = 0; fcB = 0;
        end else if (pixEnB) begin
            posB = (posB + 1) % (BHT * BVT);
            lsB  = (posB % BHT == 0);
            fsB  = (posB == 0);
            if (fsB != 0) fcB = (fcB + 1) % 256;
        end else begin
            lsB = 0; fsB = 0;
        end
    end

    task automatic compareDut(
        input string tag, input int pos, input int ls, input int fs, input int fc,
        input int ha, input int hf, input int hs, input int hb,
        input int va, input int vf, input int vs, input int vb, input bit pol,
        input logic [9:0] h, input logic [9:0] v, input logic d, input logic hsy,
        input logic vsy, input logic lst, input logic fst, input logic [7:0] fcnt);
        int ht, he, ve;
        bit deE, hsE, vsE;
        ht  = ha + hf + hs + hb;
        he  = pos % ht;
        ve  = pos / ht;
        deE = (he < ha) && (ve < va);
        hsE = (he >= ha + hf && he < ha + hf + hs) ? pol : !pol;
        vsE = (ve >= va + vf && ve < va + vf + vs) ? pol : !pol;
        checkOutput({tag, ".hpos"}, 32'(h), 32'(he));
        checkOutput({tag, ".vpos"}, 32'(v), 32'(ve));
        checkOutput({tag, ".de"}, 32'(d), 32'(deE));
        checkOutput({tag, ".hsync"}, 32'(hsy), 32'(hsE));
        checkOutput({tag, ".vsync"}, 32'(vsy), 32'(vsE));
        checkOutput({tag, ".line_start"}, 32'(lst), 32'(ls));
        checkOutput({tag, ".frame_start"}, 32'(fst), 32'(fs));
        checkOutput({tag, ".frame_count"}, 32'(fcnt), 32'(fc));
    endtask

    always @(negedge clk) begin
        if (checkOn) begin
            compareDut("A", posA, lsA, fsA, fcA, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0,
                       hposA, vposA, deA, hsyncA, vsyncA, lineStartA, frameStartA, frameCountA);
            compareDut("B", posB, lsB, fsB, fcB, BHA, BHF, BHS, BHB, BVA, BVF, BVS, BVB, 1'b1,
                       hposB, vposB, deB, hsyncB, vsyncB, lineStartB, frameStartB, frameCountB);
        end
    end

    task automatic applyStimulus(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        int n, m;
        #1 resetA = 1'b1; resetB = 1'b1;
        checkOn = 1'b1;

        // Held in reset with pix_en high across several edges: reset wins.
        applyStimulus(3);
        checkOutput("rst.hpos", 32'(hposA), 32'd799);
        checkOutput("rst.vpos", 32'(vposA), 32'd524);
        checkOutput("rst.de", 32'(deA), 32'd0);
        checkOutput("rst.hsync", 32'(hsyncA), 32'd1);
        checkOutput("rst.vsync", 32'(vsyncA), 32'd1);
        checkOutput("rst.vsyncB", 32'(vsyncB), 32'd0);

        #2 resetA = 1'b0; resetB = 1'b0;
        applyStimulus(1);
        checkOutput("first.hpos", 32'(hposA), 32'd0);
        checkOutput("first.vpos", 32'(vposA), 32'd0);
        checkOutput("first.de", 32'(deA), 32'd1);
        checkOutput("first.frame_start", 32'(frameStartA), 32'd1);
        checkOutput("first.frame_count", 32'(frameCountA), 32'd1);

        applyStimulus(639);
        checkOutput("line.de@639", 32'(deA), 32'd1);
        applyStimulus(1);
        checkOutput("line.de@640", 32'(deA), 32'd0);
        applyStimulus(15);
        checkOutput("line.hsync@655", 32'(hsyncA), 32'd1);
        applyStimulus(1);
        checkOutput("line.hsync@656", 32'(hsyncA), 32'd0);
        applyStimulus(95);
        checkOutput("line.hsync@751", 32'(hsyncA), 32'd0);
        applyStimulus(1);
        checkOutput("line.hsync@752", 32'(hsyncA), 32'd1);

        n = 0;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if (lineStartA) n++;
        end
        checkOutput("line.pulses_per_800", 32'(n), 32'd1);

        applyStimulus(47);
        checkOutput("tog.hpos_end", 32'(hposA), 32'd799);
        applyStimulus(1);
        checkOutput("tog.ls_en", 32'(lineStartA), 32'd1);
        pixEnA = 1'b0;
        applyStimulus(1);
        checkOutput("tog.ls_cleared", 32'(lineStartA), 32'd0);
        checkOutput("tog.hpos_hold0", 32'(hposA), 32'd0);
        pixEnA = 1'b1;
        applyStimulus(1);
        checkOutput("tog.hpos_adv", 32'(hposA), 32'd1);
        pixEnA = 1'b0;
        applyStimulus(1);
        checkOutput("tog.hpos_hold1", 32'(hposA), 32'd1);
        pixEnA = 1'b1;

        applyStimulus(299);
        checkOutput("mid.hpos", 32'(hposA), 32'd300);
        #2 resetA = 1'b1;
        #1;
        checkOutput("mid.rst_hpos", 32'(hposA), 32'd799);
        checkOutput("mid.rst_vpos", 32'(vposA), 32'd524);
        checkOutput("mid.rst_de", 32'(deA), 32'd0);
        applyStimulus(1);
        #2 resetA = 1'b0;
        applyStimulus(1);
        checkOutput("mid.restart_hpos", 32'(hposA), 32'd0);
        checkOutput("mid.restart_fc", 32'(frameCountA), 32'd1);

        #2 resetB = 1'b1;
        applyStimulus(1);
        #2 resetB = 1'b0;
        applyStimulus(1);
        checkOutput("B.first_fc", 32'(frameCountB), 32'd1);
        n = 0;
        m = 0;
        for (int i = 0; i < BHT * BVT; i++) begin
            @(negedge clk);
            if (vsyncB) n++;
            if (frameStartB) m++;
        end
        checkOutput("B.vsync_cycles", 32'(n), 32'(BVS * BHT));
        checkOutput("B.frame_pulses", 32'(m), 32'd1);
        checkOutput("B.second_fc", 32'(frameCountB), 32'd2);
        applyStimulus(BHT * BVT * 253);
        checkOutput("B.fc255", 32'(frameCountB), 32'd255);
        applyStimulus(BHT * BVT - 1);
        checkOutput("B.fc255_late", 32'(frameCountB), 32'd255);
        applyStimulus(1);
        checkOutput("B.fc_wrap", 32'(frameCountB), 32'd0);
        checkOutput("B.fs_wrap", 32'(frameStartB), 32'd1);

        checkOn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_timing.md
# vga_timing

Video timing generator that produces the raster scan consumed by the game renderer: hsync, vsync, de, and the beam coordinates hpos/vpos. It sits between the board pixel clock and the pong renderer. All outputs are registered and mutually aligned, so the renderer's combinational pixel logic sees one consistent beam position per pixel. The renderer clocks its game state from the rising edge of vsync, which is the end of the sync pulse.

## Interface

Parameters:
- H_ACTIVE, 640: visible pixels per line
- H_FP, 16: horizontal front porch, in pixels
- H_SYNC, 96: hsync pulse width, in pixels
- H_BP, 48: horizontal back porch, in pixels
- V_ACTIVE, 480: visible lines per frame
- V_FP, 10: vertical front porch, in lines
- V_SYNC, 2: vsync pulse width, in lines
- V_BP, 33: vertical back porch, in lines
- SYNC_POL, 0: sync active level; 0 means active-low

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- pix_en  in  1  pixel-clock enable; the raster advances only on clk edges where this is 1
- hpos  out  10  horizontal counter, 0..H_TOTAL-1
- vpos  out  10  vertical counter, 0..V_TOTAL-1
- de  out  1  data enable; high inside the active area
- hsync  out  1  horizontal sync, at SYNC_POL polarity
- vsync  out  1  vertical sync, at SYNC_POL polarity
- line_start  out  1  one-clk pulse when hpos becomes 0
- frame_start  out  1  one-clk pulse when (hpos,vpos) becomes (0,0)
- frame_count  out  8  count of frames started; wraps

## Operation

- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 at defaults); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 at defaults). Both totals must be ≤1024; elaboration fails otherwise.
- Counter advance, on each clk edge with pix_en=1:
  - hpos increments.
  - At H_TOTAL-1, hpos wraps to 0 and vpos increments.
  - At V_TOTAL-1, vpos wraps to 0 on the same edge that hpos wraps.
- de = (hpos < H_ACTIVE) && (vpos < V_ACTIVE).
- hsync is active for hpos in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). At defaults that is [656,752), 96 pixels.
- vsync is active for vpos in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC). At defaults that is lines 490–491, for every pixel of those lines.
- When a sync signal is inactive it is driven to ~SYNC_POL.
- de, hsync and vsync are registered functions of the next counter values. They change on the same edge as hpos/vpos, with zero skew.
- line_start:
  - Goes to 1 on an enabled edge where hpos becomes 0.
  - Returns to 0 on the next clk edge, whatever pix_en is.
- frame_start:
  - Same pulse rule as line_start, but fires when hpos and vpos both become 0.
  - frame_count increments by 1 on the same edge; it wraps 255→0.
- pix_en=0: all outputs hold, except that line_start and frame_start clear.

## Timing

- Reset, asynchronous: outputs take these values immediately, independent of clk.
  - hpos = H_TOTAL-1
  - vpos = V_TOTAL-1
  - de = 0
  - hsync = vsync = ~SYNC_POL
  - line_start = frame_start = 0
  - frame_count = 0
- First enabled edge after reset release:
  - hpos = 0, vpos = 0, de = 1
  - line_start = frame_start = 1
  - frame_count = 1
- Latency: one clk edge from an enabled cycle to the updated outputs. No further pipeline.
- Frame length: exactly H_TOTAL*V_TOTAL enabled cycles, which is 420000 at defaults.
- vsync rising edge, with SYNC_POL=0: occurs on the enabled edge where vpos becomes 492 and hpos becomes 0.
- Reset asserted mid-frame: outputs return to their reset values immediately. Release behaves as if coming from a fresh reset.
- reset and pix_en both high: reset wins.

## Test plan

- Reset, then release with pix_en held 1:
  - Before release: hpos=799, vpos=524, de=0, hsync=vsync=1.
  - After the first edge: (0,0), de=1, frame_start=1, frame_count=1.
- Run one full line:
  - de falls as hpos goes 639→640.
  - hsync falls as hpos goes 655→656 and rises as hpos goes 751→752.
  - line_start pulses once per 800 enabled cycles.
- Run two full frames:
  - vsync is low exactly for vpos 490–491, which is 1600 enabled cycles.
  - frame_start pulses every 420000 cycles; frame_count reads 1, then 2.
- pix_en toggling 1,0,1,0:
  - hpos advances only on enabled edges.
  - line_start is high for exactly one clk cycle even while pix_en=0.
- Assert reset at (hpos=300, vpos=200):
  - Outputs become (799, 524, de=0) before the next clk edge.
  - Frame restarts at (0,0) after release.
- Force 256 frames (or preload frame_count to 255): the next frame_start wraps frame_count to 0.
